// File: rtl/jtframe_sdram_arb_pkg.sv
`default_nettype none
// ============================================================================
// jtframe_sdram_arb_pkg
// Shared widths, FSM encoding and grant-index sizing for the SDRAM arbiter.
// Revision: 1.0
// ============================================================================
package jtframe_sdram_arb_pkg;

  localparam int DEF_AW    = 22;
  localparam int DEF_DW    = 16;
  localparam int DEF_SLOTS = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RFSH = 2'd3;

  // Grant index width; never below one bit so a 1-bit pointer still exists.
  function automatic int gnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_GW = gnt_width(DEF_SLOTS);

endpackage
`default_nettype wire

// File: rtl/jtframe_arb_slot.sv
`default_nettype none
// ============================================================================
// jtframe_arb_slot
// One-word read cache for a single requester: hit compare, ok flag, fill port.
// Revision: 1.0
// ============================================================================
module jtframe_arb_slot
  import jtframe_sdram_arb_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] i_addr,
  input  logic          i_cs,
  input  logic          i_downloading,
  input  logic          i_fill,
  input  logic [AW-1:0] i_fill_addr,
  input  logic [DW-1:0] i_fill_data,
  output logic          o_ok,
  output logic [DW-1:0] o_dout,
  output logic          o_pend
);

  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          ok_q, ok_d;
  logic          w_hit;
  logic          w_fill_hit;

  always_comb begin
    w_hit      = valid_q && (i_addr == addr_q);
    w_fill_hit = i_fill && (i_addr == i_fill_addr);
    addr_d     = addr_q;
    data_d     = data_q;
    valid_d    = valid_q;
    if (i_fill) begin
      addr_d  = i_fill_addr;
      data_d  = i_fill_data;
      valid_d = 1'b1;
    end
    if (i_downloading) begin
      valid_d = 1'b0;
    end
    // ok follows the post-fill cache contents so a fill reports data one cycle earlier
    ok_d = i_cs && !i_downloading && (i_fill ? w_fill_hit : w_hit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ok_q    <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ok_q    <= ok_d;
    end
  end

  assign o_ok   = ok_q;
  assign o_dout = data_q;
  assign o_pend = i_cs && !w_hit && !i_downloading;

endmodule
`default_nettype wire

// File: rtl/jtframe_sdram_arb.sv
`default_nettype none
// ============================================================================
// jtframe_sdram_arb
// Round-robin arbiter sharing one SDRAM read port among cached ROM slots.
// Revision: 1.0
// ============================================================================
module jtframe_sdram_arb
  import jtframe_sdram_arb_pkg::*;
#(
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW,
  parameter int SLOTS = DEF_SLOTS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SLOTS*AW-1:0] slot_addr,
  input  logic [SLOTS-1:0]    slot_cs,
  output logic [SLOTS-1:0]    slot_ok,
  output logic [SLOTS*DW-1:0] slot_dout,
  input  logic                downloading,
  input  logic                refresh_req,
  output logic [AW-1:0]       sdram_addr,
  output logic                sdram_req,
  output logic                sdram_rfsh,
  input  logic                sdram_ack,
  input  logic                data_rdy,
  input  logic [DW-1:0]       data_read
);

  localparam int GW = gnt_width(SLOTS);

  logic [1:0]    st_q, st_d;
  logic [GW-1:0] ptr_q, ptr_d;
  logic [GW-1:0] gnt_q, gnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          req_q, req_d;
  logic          rfsh_q, rfsh_d;
  logic          discard_q, discard_d;

  logic [SLOTS-1:0] w_pend;
  logic [AW-1:0]    w_slot_addr [SLOTS];
  logic             w_any;
  logic [GW-1:0]    w_pick;
  logic [GW:0]      w_idx;
  logic             w_fill;

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    assign w_slot_addr[i] = slot_addr[i*AW +: AW];

    jtframe_arb_slot #(
      .AW (AW),
      .DW (DW)
    ) u_slot (
      .clk           (clk),
      .rst           (rst),
      .i_addr        (slot_addr[i*AW +: AW]),
      .i_cs          (slot_cs[i]),
      .i_downloading (downloading),
      .i_fill        (w_fill && (gnt_q == GW'(i))),
      .i_fill_addr   (addr_q),
      .i_fill_data   (data_read),
      .o_ok          (slot_ok[i]),
      .o_dout        (slot_dout[i*DW +: DW]),
      .o_pend        (w_pend[i])
    );
  end

  // First pending slot at or after the pointer, wrapping modulo SLOTS
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_idx  = '0;
    for (int k = 0; k < SLOTS; k++) begin
      w_idx = {1'b0, ptr_q} + (GW+1)'(k);
      if (w_idx >= (GW+1)'(SLOTS)) begin
        w_idx = w_idx - (GW+1)'(SLOTS);
      end
      if (!w_any && w_pend[w_idx[GW-1:0]]) begin
        w_any  = 1'b1;
        w_pick = w_idx[GW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= ST_IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      addr_q    <= '0;
      req_q     <= 1'b0;
      rfsh_q    <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      addr_q    <= addr_d;
      req_q     <= req_d;
      rfsh_q    <= rfsh_d;
      discard_q <= discard_d;
    end
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_IDLE: begin
        if (refresh_req) begin
          st_d = ST_RFSH;
        end else if (!downloading && w_any) begin
          st_d = ST_REQ;
        end
      end
      ST_REQ:  if (sdram_ack) st_d = ST_WAIT;
      ST_WAIT: if (data_rdy)  st_d = ST_IDLE;
      ST_RFSH: if (sdram_ack) st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_d    = addr_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    req_d     = req_q;
    rfsh_d    = rfsh_q;
    discard_d = discard_q;
    w_fill    = 1'b0;
    case (st_q)
      ST_IDLE: begin
        if (refresh_req) begin
          rfsh_d = 1'b1;
        end else if (!downloading && w_any) begin
          gnt_d     = w_pick;
          addr_d    = w_slot_addr[w_pick];
          req_d     = 1'b1;
          discard_d = 1'b0;
        end
      end
      ST_REQ: begin
        if (downloading) discard_d = 1'b1;
        if (sdram_ack)   req_d     = 1'b0;
      end
      ST_WAIT: begin
        if (downloading) discard_d = 1'b1;
        if (data_rdy) begin
          // A download seen at any point of the transaction voids the fill
          w_fill = !discard_q && !downloading;
          if (!downloading) begin
            ptr_d = (gnt_q == GW'(SLOTS-1)) ? '0 : gnt_q + GW'(1);
          end
        end
      end
      ST_RFSH: begin
        if (sdram_ack) rfsh_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign sdram_addr = addr_q;
  assign sdram_req  = req_q;
  assign sdram_rfsh = rfsh_q;

endmodule
`default_nettype wire

// File: tb/tb_jtframe_sdram_arb.sv
`default_nettype none
// ============================================================================
// tb_jtframe_sdram_arb
// Self-checking bench: SDRAM controller model, address scoreboard, vector table.
// Revision: 1.0
// ============================================================================
module tb_jtframe_sdram_arb;

  localparam int AW = 22;
  localparam int DW = 16;
  localparam int SLOTS = 4;
  localparam int ACK_DLY = 2;
  localparam int RDY_DLY = 3;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [SLOTS*AW-1:0] slot_addr = '0;
  logic [SLOTS-1:0]    slot_cs = '0;
  logic [SLOTS-1:0]    slot_ok;
  logic [SLOTS*DW-1:0] slot_dout;
  logic                downloading = 1'b0;
  logic                refresh_req = 1'b0;
  logic [AW-1:0]       sdram_addr;
  logic                sdram_req;
  logic                sdram_rfsh;
  logic                sdram_ack = 1'b0;
  logic                data_rdy = 1'b0;
  logic [DW-1:0]       data_read = '0;

  logic inj_ack = 1'b0;
  logic inj_rdy = 1'b0;

  int total = 0;
  int bad = 0;
  logic [AW-1:0] exp_q [$];

  typedef struct {
    logic [3:0] cs;
    logic [3:0] alt;
    logic [3:0] exp_ok;
  } vec_t;

  jtframe_sdram_arb #(.AW(AW), .DW(DW), .SLOTS(SLOTS)) dut (
    .clk         (clk),
    .rst         (rst),
    .slot_addr   (slot_addr),
    .slot_cs     (slot_cs),
    .slot_ok     (slot_ok),
    .slot_dout   (slot_dout),
    .downloading (downloading),
    .refresh_req (refresh_req),
    .sdram_addr  (sdram_addr),
    .sdram_req   (sdram_req),
    .sdram_rfsh  (sdram_rfsh),
    .sdram_ack   (sdram_ack),
    .data_rdy    (data_rdy),
    .data_read   (data_read)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
    if (a == 22'h100) return 16'hBEEF;
    return a[15:0] ^ 16'hA5C3;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    slot_addr[i*AW +: AW] = a;
  endtask

  function automatic logic [DW-1:0] dout(input int i);
    return slot_dout[i*DW +: DW];
  endfunction

  task automatic wait_req(input string nm, input logic lvl);
    int n = 0;
    while (sdram_req !== lvl && n < 60) begin
      tick;
      n++;
    end
    chk(nm, sdram_req, lvl);
  endtask

  task automatic wait_rdy(input string nm);
    int n = 0;
    while (data_rdy !== 1'b1 && n < 60) begin
      tick;
      n++;
    end
    chk(nm, data_rdy, 1);
  endtask

  task automatic wait_ok(input string nm, input logic [3:0] m);
    int n = 0;
    do begin
      tick;
      n++;
    end while ((slot_ok & m) != m && n < 200);
    chk(nm, slot_ok & m, m);
  endtask

  // Controller model: acks ACK_DLY cycles after a request, data RDY_DLY after the ack
  initial begin
    int ph = 0;
    int cnt = 0;
    logic [AW-1:0] ra = '0;
    forever begin
      @(negedge clk);
      sdram_ack = inj_ack;
      data_rdy  = inj_rdy;
      if (inj_rdy) data_read = 16'h1234;
      chk("req_rfsh_excl", sdram_req & sdram_rfsh, 0);
      if (rst) begin
        ph  = 0;
        cnt = 0;
      end else begin
        case (ph)
          0: if (sdram_req || sdram_rfsh) begin
            ph  = sdram_req ? 1 : 3;
            cnt = 0;
            ra  = sdram_addr;
            if (sdram_req) begin
              if (exp_q.size() == 0) chk("sb_unexpected_req", {42'd0, ra}, 64'hFFFF_FFFF);
              else chk("sb_addr", ra, exp_q.pop_front());
            end
          end
          1, 3: begin
            cnt++;
            if (cnt == ACK_DLY) begin
              sdram_ack = 1'b1;
              ph  = (ph == 1) ? 2 : 0;
              cnt = 0;
            end
          end
          2: begin
            cnt++;
            if (cnt == RDY_DLY) begin
              data_rdy  = 1'b1;
              data_read = mem(ra);
              ph = 0;
            end
          end
          default: ph = 0;
        endcase
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl [6];
    logic [AW-1:0] a2 [4];

    tbl[0] = '{4'b1111, 4'b0000, 4'b1111};
    tbl[1] = '{4'b0101, 4'b0000, 4'b0101};
    tbl[2] = '{4'b0000, 4'b1111, 4'b0000};
    tbl[3] = '{4'b1010, 4'b0101, 4'b1010};
    tbl[4] = '{4'b0011, 4'b1100, 4'b0011};
    tbl[5] = '{4'b1100, 4'b0011, 4'b1100};

    // Reset state
    tick; tick;
    chk("rst_ok", slot_ok, 0);
    chk("rst_req", sdram_req, 0);
    chk("rst_rfsh", sdram_rfsh, 0);
    chk("rst_addr", sdram_addr, 0);
    chk("rst_dout", slot_dout, 0);

    // Single miss, then repeated hits
    rst = 1'b0;
    slot_cs = 4'b0001;
    set_addr(0, 22'h100);
    exp_q.push_back(22'h100);
    tick; chk("t1_req_c1", sdram_req, 1); chk("t1_addr", sdram_addr, 22'h100);
    tick; chk("t1_req_c2", sdram_req, 1);
    tick; chk("t1_req_c3", sdram_req, 1);
    tick; chk("t1_req_c4", sdram_req, 0);
    tick; tick; chk("t1_ok_c6", slot_ok[0], 0);
    tick; chk("t1_ok_c7", slot_ok[0], 1); chk("t1_dout", dout(0), 16'hBEEF);
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("t1_hit_ok", slot_ok[0], 1);
      chk("t1_hit_noreq", sdram_req, 0);
    end

    // Four simultaneous misses, two rounds
    rst = 1'b1; slot_cs = '0;
    tick;
    rst = 1'b0;
    slot_cs = 4'hF;
    for (int i = 0; i < 4; i++) begin
      set_addr(i, 22'h200 + AW'(i));
      exp_q.push_back(22'h200 + AW'(i));
    end
    wait_ok("t2_round1", 4'hF);
    for (int i = 0; i < 4; i++) begin
      a2[i] = 22'h280 + AW'(i);
      set_addr(i, a2[i]);
      exp_q.push_back(a2[i]);
    end
    wait_ok("t2_round2", 4'hF);
    chk("t2_sb_empty", exp_q.size(), 0);
    for (int i = 0; i < 4; i++) chk("t2_dout", dout(i), mem(a2[i]));

    // Hit-path vectors
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 4; i++) set_addr(i, tbl[r].alt[i] ? a2[i] + 22'h1000 : a2[i]);
      slot_cs = tbl[r].cs;
      tick;
      chk($sformatf("tbl%0d_ok", r), slot_ok, tbl[r].exp_ok);
      chk($sformatf("tbl%0d_noreq", r), sdram_req, 0);
    end
    for (int i = 0; i < 4; i++) set_addr(i, a2[i]);
    slot_cs = '0;
    tick;

    // Refresh wins over a simultaneous miss; refresh during WAIT waits for data
    slot_cs = 4'b0100;
    set_addr(2, 22'h500);
    exp_q.push_back(22'h500);
    refresh_req = 1'b1;
    tick;
    chk("t3_rfsh_first", sdram_rfsh, 1);
    chk("t3_no_req", sdram_req, 0);
    refresh_req = 1'b0;
    wait_req("t3_req_after_rfsh", 1'b1);
    wait_req("t3_req_ack", 1'b0);
    refresh_req = 1'b1;
    begin
      int n = 0;
      while (data_rdy !== 1'b1 && n < 60) begin
        chk("t3_rfsh_held", sdram_rfsh, 0);
        tick;
        n++;
      end
    end
    chk("t3_rdy_seen", data_rdy, 1);
    chk("t3_ok2", slot_ok[2], 1);
    chk("t3_dout2", dout(2), mem(22'h500));
    tick;
    chk("t3_rfsh_after", sdram_rfsh, 1);
    chk("t3_req_after", sdram_req, 0);
    refresh_req = 1'b0;
    begin
      int n = 0;
      while (sdram_rfsh && n < 60) begin
        tick;
        n++;
      end
    end
    chk("t3_rfsh_done", sdram_rfsh, 0);

    // Address change during WAIT: stale fill, then re-arbitration
    slot_cs = 4'b0010;
    set_addr(1, 22'h20);
    exp_q.push_back(22'h20);
    exp_q.push_back(22'h21);
    wait_req("t4_req", 1'b1);
    wait_req("t4_ack", 1'b0);
    set_addr(1, 22'h21);
    begin
      int n = 0;
      while (data_rdy !== 1'b1 && n < 60) begin
        chk("t4_ok_low", slot_ok[1], 0);
        tick;
        n++;
      end
    end
    chk("t4_rdy_seen", data_rdy, 1);
    chk("t4_stale_fill", dout(1), mem(22'h20));
    chk("t4_ok_stale", slot_ok[1], 0);
    wait_ok("t4_ok_new", 4'b0010);
    chk("t4_dout_new", dout(1), mem(22'h21));

    // Download during WAIT: completes, no write, everything invalid
    slot_cs = 4'b0001;
    set_addr(0, a2[0]);
    tick;
    chk("t5_ok0_before", slot_ok[0], 1);
    slot_cs = 4'b1001;
    set_addr(3, 22'h400);
    exp_q.push_back(22'h400);
    wait_req("t5_req", 1'b1);
    wait_req("t5_ack", 1'b0);
    downloading = 1'b1;
    wait_rdy("t5_rdy_seen");
    slot_cs = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      tick;
      chk("t5_dl_ok", slot_ok, 0);
      chk("t5_dl_noreq", sdram_req, 0);
    end
    chk("t5_discard", dout(3), mem(a2[3]));
    downloading = 1'b0;
    exp_q.push_back(a2[0]);
    wait_req("t5_remiss", 1'b1);
    wait_ok("t5_ok0_after", 4'b0001);
    chk("t5_dout0", dout(0), mem(a2[0]));

    // Reset during REQ; late ack/data ignored
    slot_cs = 4'b0100;
    set_addr(2, 22'h600);
    exp_q.push_back(22'h600);
    wait_req("t6_req", 1'b1);
    tick;
    chk("t6_still_req", sdram_req, 1);
    rst = 1'b1;
    slot_cs = '0;
    tick;
    chk("t6_rst_req", sdram_req, 0);
    chk("t6_rst_ok", slot_ok, 0);
    rst = 1'b0;
    tick;
    inj_ack = 1'b1;
    tick;
    inj_ack = 1'b0;
    inj_rdy = 1'b1;
    tick;
    inj_rdy = 1'b0;
    tick;
    chk("t6_late_req", sdram_req, 0);
    chk("t6_late_rfsh", sdram_rfsh, 0);
    chk("t6_late_ok", slot_ok, 0);
    chk("t6_late_dout2", dout(2), 0);
    slot_cs = 4'b0010;
    set_addr(1, 22'h700);
    exp_q.push_back(22'h700);
    tick;
    chk("t6_fresh_req", sdram_req, 1);
    chk("t6_fresh_addr", sdram_addr, 22'h700);
    wait_ok("t6_fresh_ok", 4'b0010);
    chk("t6_fresh_dout", dout(1), mem(22'h700));
    chk("sb_empty_end", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jtframe_sdram_arb.md
Name: jtframe_sdram_arb

Overview:
- Round-robin arbiter that shares the single SDRAM read port among SLOTS game-side ROM requesters (main CPU, sound CPU, char, obj).
- Sits between the game core and the SDRAM controller.
- Each slot has a one-word cache (last address and data), so repeated reads of the same address do not touch SDRAM.
- Also schedules refresh and blocks access during ROM download.

Parameters:
- AW, 22, address width in 16-bit words.
- DW, 16, data width.
- SLOTS, 4, number of requesters (2..8).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- slot_addr  in  SLOTS*AW  per-slot word address; slot i occupies bits [i*AW +: AW].
- slot_cs  in  SLOTS  per-slot read request (level).
- slot_ok  out  SLOTS  per-slot data valid for the current slot_addr (registered).
- slot_dout  out  SLOTS*DW  per-slot cached data.
- downloading  in  1  ROM download in progress.
- refresh_req  in  1  refresh wanted (level, from line timer).
- sdram_addr  out  AW  address to controller (registered).
- sdram_req  out  1  read request, held until sdram_ack.
- sdram_rfsh  out  1  refresh request, held until sdram_ack.
- sdram_ack  in  1  controller accepted the req or rfsh (1-cycle pulse).
- data_rdy  in  1  read data valid (1-cycle pulse).
- data_read  in  DW  SDRAM read data.

Behaviour:
- Reset values: all outputs 0, every valid bit cleared, FSM in IDLE, round-robin pointer = 0.
- Per-slot cache: cached address, cached data, valid bit.
  - hit_i = valid_i & (slot_addr_i == cached address_i).
  - slot_ok_i is registered as slot_cs_i & hit_i & !downloading, so a hit gives 1-cycle latency.
  - slot_ok_i drops the cycle after slot_addr_i changes to a non-matching address.
  - slot_dout_i always shows the cached data.
- Pending: pend_i = slot_cs_i & !hit_i & !downloading.
- FSM states:
  - IDLE:
    - If refresh_req, go to RFSH and set sdram_rfsh = 1. Refresh has priority over slots.
    - Otherwise, if any pend_i, grant the first pending slot at or after the pointer, wrapping modulo SLOTS.
    - On grant: latch sdram_addr = slot_addr_g, set sdram_req = 1, store g, go to REQ.
  - REQ: on sdram_ack, sdram_req = 0, go to WAIT.
  - WAIT: on data_rdy, go to IDLE.
    - If !discard: cached data_g = data_read, cached address_g = latched sdram_addr, valid_g = 1.
    - Pointer = g+1 (wraps to 0 after SLOTS-1).
  - RFSH: on sdram_ack, sdram_rfsh = 0, go to IDLE.
- Miss latency: cs with a new address at cycle 0 -> sdram_req high at cycle 1 (if IDLE).
  - slot_ok rises the cycle after the data_rdy cycle.
- The address used for a cache fill is the one latched at grant.
  - If slot_addr changes during REQ/WAIT, the stale fill is still written.
  - hit fails for the new address, so the slot re-arbitrates; slot_ok stays low throughout.
- slot_cs dropping mid-transaction: the transaction completes and the cache fills; slot_ok stays 0.
- downloading:
  - While high: all valid bits clear every cycle, no new grants, and the RR pointer is kept.
  - An in-flight REQ/WAIT completes its handshake but sets discard, so no cache write.
  - RFSH is still served.
- data_rdy outside WAIT and sdram_ack outside REQ/RFSH are ignored.
- sdram_req and sdram_rfsh are never high together.
- Reset mid-transaction: outputs drop on the next edge. The controller must tolerate an abandoned request.

Decomposition:
- Shared package/header jtframe_sdram_arb_pkg:
  - FSM state encoding (IDLE=0, REQ=1, WAIT=2, RFSH=3).
  - Default widths AW/DW.
  - A clog2 constant for the grant index width.
- Sub-module jtframe_arb_slot:
  - One per slot, via a generate loop.
  - Holds the cache registers, the hit compare, the slot_ok register and the fill/clear inputs.
- The top level holds the FSM, the round-robin pick and the SDRAM-side registers.

Test Plan:
- Reset, then slot0 cs=1, addr=0x00100; controller acks at cycle 3 and sends data_rdy with 0xBEEF at cycle 6 -> sdram_req high at cycles 1-3, slot_ok[0] rises at cycle 7, slot_dout0=0xBEEF. A repeat read of the same address gives no sdram_req and slot_ok stays high.
- All 4 slots cs with distinct misses at the same cycle -> grant order 0,1,2,3. Re-missing all four -> order continues 0,1,2,3 from the pointer; no slot is granted twice before the others.
- refresh_req and slot2 miss in the same cycle while IDLE -> sdram_rfsh first, then sdram_req for slot2 after the ack. refresh_req during WAIT -> served only after data_rdy.
- slot1 changes address from 0x20 to 0x21 during WAIT -> fill writes address 0x20, slot_ok[1] stays 0, and a second request goes out with sdram_addr=0x21.
- downloading asserted during WAIT -> handshake completes, no cache write, all slot_ok=0, no new sdram_req until downloading=0. Afterwards, a previously cached address misses again.
- rst pulsed during REQ -> sdram_req=0 and slot_ok=0 next cycle; a late sdram_ack or data_rdy after reset is ignored.
